// File: rtl/alu_op_sequencer.sv
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Command-issue stage in front of an 8-bit combinational ALU.
//                Registers operands/opcode on a valid/ready command handshake,
//                captures the ALU result one cycle later, and presents it
//                downstream on its own valid/ready handshake. An accumulator
//                holds the last result so commands can chain on it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
  parameter int                 DATA_W   = 8,
  parameter logic [DATA_W-1:0]  ACC_INIT = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  // command side
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  input  logic              cmd_acc_i,
  input  logic              acc_clr_i,
  // ALU interface
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [2:0]        alu_op_o,
  input  logic [DATA_W-1:0] alu_res_i,
  // result side
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic [2:0]        res_op_o,
  output logic [DATA_W-1:0] acc_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;

  // Accumulator value as seen by a command on this edge: a simultaneous clear
  // takes effect before the operand is sampled.
  logic [DATA_W-1:0] acc_operand;
  assign acc_operand = acc_clr_i ? ACC_INIT : acc;

  // Single-process FSM: state, ALU operand registers, result registers and
  // accumulator; cmd_ready_o/res_valid_o are registered to track the state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b1;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_op_o    <= 3'b000;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
      alu_op_o    <= 3'b000;
      acc         <= ACC_INIT;
    end else begin
      // A clear outside the EXEC edge always wins; EXEC overrides below.
      if (acc_clr_i) begin
        acc <= ACC_INIT;
      end

      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            alu_op_o    <= cmd_op_i;
            alu_b_o     <= cmd_b_i;
            alu_a_o     <= cmd_acc_i ? acc_operand : cmd_a_i;
            cmd_ready_o <= 1'b0;
            state       <= EXEC;
          end
        end

        EXEC: begin
          res_data_o  <= alu_res_i;
          res_op_o    <= alu_op_o;
          acc         <= acc_clr_i ? ACC_INIT : alu_res_i;
          res_valid_o <= 1'b1;
          state       <= RESP;
        end

        RESP: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          res_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign acc_o = acc;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Directed self-checking bench for alu_op_sequencer, with a
//                behavioural model of the downstream combinational ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_acc;
  logic       acc_clr;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_res;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_op;
  logic [7:0] acc;

  int n_cmp = 0;
  int n_err = 0;

  alu_op_sequencer #(
    .DATA_W   (8),
    .ACC_INIT (8'h00)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .cmd_acc_i   (cmd_acc),
    .acc_clr_i   (acc_clr),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_res_i   (alu_res),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_op_o    (res_op),
    .acc_o       (acc)
  );

  // Behavioural model of the external combinational ALU
  always_comb begin
    alu_res = 8'h00;
    case (alu_op)
      3'b000: alu_res = alu_a + alu_b;
      3'b001: alu_res = alu_a - alu_b;
      3'b010: alu_res = alu_a << alu_b[2:0];
      3'b011: alu_res = alu_a >> alu_b[2:0];
      3'b100: alu_res = alu_a & alu_b;
      3'b101: alu_res = alu_a | alu_b;
      3'b110: alu_res = alu_a ^ alu_b;
      3'b111: alu_res = (alu_a == alu_b) ? 8'h01 : 8'h00;
      default: alu_res = 8'h00;
    endcase
  end

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full command with res_ready held high; optional clear on the EXEC edge
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic use_acc, input logic clr_exec,
                         input logic [7:0] exp_res, input logic [7:0] exp_acc);
    check({tag, ":ready_before"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_acc   = use_acc;
    step();
    cmd_valid = 1'b0;
    cmd_acc   = 1'b0;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    check({tag, ":exec_ready"}, cmd_ready, 0);
    check({tag, ":exec_valid"}, res_valid, 0);
    acc_clr = clr_exec;
    step();
    acc_clr = 1'b0;
    check({tag, ":resp_valid"}, res_valid, 1);
    check({tag, ":resp_data"},  res_data, exp_res);
    check({tag, ":resp_op"},    res_op, op);
    check({tag, ":resp_acc"},   acc, exp_acc);
    check({tag, ":resp_ready"}, cmd_ready, 0);
    step();
    check({tag, ":done_valid"}, res_valid, 0);
    check({tag, ":done_ready"}, cmd_ready, 1);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    cmd_acc   = 1'b0;
    acc_clr   = 1'b0;
    res_ready = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst:cmd_ready", cmd_ready, 1);
    check("rst:res_valid", res_valid, 0);
    check("rst:res_data",  res_data, 8'h00);
    check("rst:res_op",    res_op, 3'b000);
    check("rst:alu_a",     alu_a, 8'h00);
    check("rst:alu_b",     alu_b, 8'h00);
    check("rst:alu_op",    alu_op, 3'b000);
    check("rst:acc",       acc, 8'h00);

    // Basic ADD and ALU-side operands
    run_cmd("add", 3'b000, 8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 8'h41);
    check("add:alu_a_hold", alu_a, 8'h3C);
    check("add:alu_b_hold", alu_b, 8'h05);

    // Wrap and EQL
    run_cmd("add_wrap", 3'b000, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cmd("sub_wrap", 3'b001, 8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 8'hFF);
    run_cmd("eql_hit",  3'b111, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'h01, 8'h01);
    run_cmd("eql_miss", 3'b111, 8'h5A, 8'h5B, 1'b0, 1'b0, 8'h00, 8'h00);

    // Back-pressure: SLL 0x81 by 1, hold res_ready low, offer a competing command
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 3'b010;
    cmd_a     = 8'h81;
    cmd_b     = 8'h01;
    step();
    cmd_op = 3'b000;
    cmd_a  = 8'h11;
    cmd_b  = 8'h22;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp:valid",  res_valid, 1);
      check("bp:data",   res_data, 8'h02);
      check("bp:ready",  cmd_ready, 0);
      check("bp:alu_op", alu_op, 3'b010);
      step();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    check("bp:op", res_op, 3'b010);
    step();
    check("bp:release_valid", res_valid, 0);
    check("bp:release_ready", cmd_ready, 1);
    step();
    check("bp:idle_valid",  res_valid, 0);
    check("bp:acc",         acc, 8'h02);
    check("bp:no_accept_a", alu_a, 8'h81);

    // Accumulator chain; cmd_a is driven with junk and must be ignored
    run_cmd("chain_add", 3'b000, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 8'h30);
    run_cmd("chain_xor", 3'b110, 8'hA5, 8'hFF, 1'b1, 1'b0, 8'hCF, 8'hCF);
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    check("clr_idle:acc", acc, 8'h00);
    run_cmd("chain_or", 3'b101, 8'hA5, 8'h0F, 1'b1, 1'b0, 8'h0F, 8'h0F);

    // Clear collision on the EXEC edge
    run_cmd("clr_exec", 3'b100, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'h30, 8'h00);

    // Reset during EXEC
    run_cmd("pre_rst", 3'b000, 8'h07, 8'h07, 1'b0, 1'b0, 8'h0E, 8'h0E);
    cmd_valid = 1'b1;
    cmd_op    = 3'b000;
    cmd_a     = 8'h01;
    cmd_b     = 8'h01;
    step();
    cmd_valid = 1'b0;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    check("rst_exec:valid", res_valid, 0);
    check("rst_exec:ready", cmd_ready, 1);
    check("rst_exec:acc",   acc, 8'h00);
    step();
    check("rst_exec:valid_after", res_valid, 0);

    // Reset during RESP with result held back
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 3'b000;
    cmd_a     = 8'h21;
    cmd_b     = 8'h01;
    step();
    cmd_valid = 1'b0;
    step();
    check("rst_resp:pre_valid", res_valid, 1);
    check("rst_resp:pre_data",  res_data, 8'h22);
    reset = 1'b1;
    step();
    reset     = 1'b0;
    res_ready = 1'b1;
    check("rst_resp:valid", res_valid, 0);
    check("rst_resp:ready", cmd_ready, 1);
    check("rst_resp:acc",   acc, 8'h00);
    check("rst_resp:data",  res_data, 8'h00);
    step();
    check("rst_resp:valid_after", res_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
